or1k_dpram_be_clr: RTL and testbench
====================================

# or1k_dpram_be_clr

Parametrised single-clock true dual-port RAM for the OR1K processing unit. It adds byte-enable writes, a selectable read-during-write mode, a deterministic same-address collision policy with a collision flag, an optional output pipeline register, and a hardware clear engine that sweeps the array to a known value after reset or on request. Intended for tightly-coupled cache tag/data stores and register-file backing where both ports share the core clock.

## Interface
- ADDR_WIDTH, 8: address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- RDW_MODE, 0: same-port read-during-write; 0 = write-first (new data), 1 = read-first (old data).
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, latency 2.
- CLEAR_VALUE, 0: DATA_WIDTH-bit word written by the clear engine.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clear_i  in  1  request a full-array clear; sampled in IDLE only.
- busy_o  out  1  clear engine active; port accesses ignored.
- collision_o  out  1  one-cycle pulse: same-address access with at least one write.
- en_a / en_b  in  1  port access enable.
- we_a / we_b  in  1  write (1) or read (0).
- be_a / be_b  in  NB  byte write enables; ignored on reads.
- addr_a / addr_b  in  ADDR_WIDTH  word address.
- din_a / din_b  in  DATA_WIDTH  write data.
- dout_a / dout_b  out  DATA_WIDTH  read data.
- valid_a / valid_b  out  1  dout for the corresponding access is valid this cycle.

## Operation
- FSM states: CLEAR, IDLE. rst forces CLEAR with clear counter = 0.
- CLEAR: write CLEAR_VALUE to mem[counter] each cycle, counter +1; at counter = 2^ADDR_WIDTH-1, write and go to IDLE. busy_o = 1 throughout. en_a/en_b are ignored and valid_x stays 0. clear_i is ignored.
- IDLE: busy_o = 0. If clear_i = 1, go to CLEAR with counter = 0; any access in that same cycle is still performed.
- The counter is exactly ADDR_WIDTH bits; wrap-around is never reached because the FSM exits at the last address.
- Access (en_x = 1 in IDLE): every enabled access, read or write, produces one valid_x pulse with dout_x.
  - Read: dout = mem[addr].
  - Write: bytes with be = 1 are updated.
  - dout on a write: RDW_MODE 0 gives the merged new word (new enabled bytes, old other bytes); RDW_MODE 1 gives the old word.
  - Write with be = 0: no memory change; dout = old word.
- Cross-port, same address, same cycle:
  - Both write: per byte, A wins where both be bits are set; lanes enabled only by B take B's data.
  - One reads, other writes: the reader gets the old word.
  - Each port's own dout follows its RDW_MODE on its own write; the merged word excludes the other port's bytes.
  - collision_o pulses if en_a & en_b & addr_a == addr_b & (we_a | we_b).
- dout_x holds its last value when there is no access. The memory array itself is not reset; the clear engine provides initialisation.

## Timing
- Reset values: dout_a = dout_b = 0, valid_a = valid_b = 0, collision_o = 0, busy_o = 1.
- After rst deasserts, busy_o stays 1 for exactly 2^ADDR_WIDTH rising edges, then drops. The first accepted access is in the cycle where busy_o = 0.
- clear_i in IDLE: busy_o rises on the next edge and stays high for 2^ADDR_WIDTH cycles.
- Read latency: OUT_REG = 0 gives dout/valid on the edge after the request; OUT_REG = 1 gives them two edges after. Full throughput of one access per port per cycle.
- collision_o uses the same latency as valid.
- A write is visible to a read on either port issued the following cycle.
- rst asserted mid-operation: outputs go to reset values immediately, the pipeline is flushed (pending valid pulses are dropped), and the clear restarts from address 0.

## Test plan
- Reset and clear (ADDR_WIDTH = 4, CLEAR_VALUE = 32'hDEADBEEF): release rst -> busy_o high exactly 16 cycles; reads of addr 0..15 -> all 32'hDEADBEEF.
- Byte enables: mem[3] = 32'h11223344; A writes 32'hAABBCCDD with be = 4'b0101 -> a B read of addr 3 the next cycle returns 32'h11BB33DD.
- RDW mode: write 32'h55 to a location holding 32'h99 -> RDW_MODE 0 gives dout 32'h55, RDW_MODE 1 gives dout 32'h99, one cycle later (two with OUT_REG = 1).
- Write collision: A writes 32'hAAAAAAAA with be = 4'b0011, B writes 32'hBBBBBBBB with be = 4'b0110, same addr, mem = 0 -> collision_o pulses; the location holds 32'h00BBAAAA.
- Read/write collision: A reads addr 7 (holds 32'h1) while B writes 32'h2 to addr 7 -> dout_a = 32'h1, collision_o = 1; the next read returns 32'h2.
- Mid-clear reset and request: assert rst at clear counter 9 -> busy_o is 16 cycles after release. clear_i in IDLE concurrent with an A read -> the read is valid, then busy_o = 1 for 16 cycles; accesses during busy produce no valid.

Source files
------------

// File: rtl/or1k_dpram_be_clr_if.sv
// Access bundle for the OR1K dual-port byte-enable RAM: two independent ports
// carrying request (en/we/be/addr/din) and response (dout/valid) signals.
interface or1k_dpram_be_clr_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  en_a;
    logic                  we_a;
    logic [NB-1:0]         be_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  valid_a;

    logic                  en_b;
    logic                  we_b;
    logic [NB-1:0]         be_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  valid_b;

    modport master (
        output en_a, we_a, be_a, addr_a, din_a,
        output en_b, we_b, be_b, addr_b, din_b,
        input  dout_a, valid_a, dout_b, valid_b
    );

    modport slave (
        input  en_a, we_a, be_a, addr_a, din_a,
        input  en_b, we_b, be_b, addr_b, din_b,
        output dout_a, valid_a, dout_b, valid_b
    );
endinterface

// File: rtl/or1k_dpram_be_clr.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// A-wins collision policy, optional output register and a sweeping clear engine.
module or1k_dpram_be_clr #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           RDW_MODE    = 0,
    parameter int unsigned           OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    output logic                busy_o,
    output logic                collision_o,
    or1k_dpram_be_clr_if.slave  bus
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  acc_a, acc_b, wr_a, wr_b, same_addr, collide;
    logic [DATA_WIDTH-1:0] old_a, old_b, rdata_a, rdata_b;

    logic                  valid_a_q, valid_b_q, collision_q;
    logic [DATA_WIDTH-1:0] dout_a_q, dout_b_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         be
    );
        merge_bytes = old_w;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) merge_bytes[i*8 +: 8] = new_w[i*8 +: 8];
        end
    endfunction

    always_comb begin
        acc_a     = (state_q == S_IDLE) && bus.en_a;
        acc_b     = (state_q == S_IDLE) && bus.en_b;
        wr_a      = acc_a && bus.we_a;
        wr_b      = acc_b && bus.we_b;
        same_addr = (bus.addr_a == bus.addr_b);
        collide   = acc_a && acc_b && same_addr && (bus.we_a || bus.we_b);
        old_a     = mem[bus.addr_a];
        old_b     = mem[bus.addr_b];
        // Each port's merged word only folds in its own lanes, never the other port's.
        rdata_a   = (wr_a && RDW_MODE == 0) ? merge_bytes(old_a, bus.din_a, bus.be_a) : old_a;
        rdata_b   = (wr_b && RDW_MODE == 0) ? merge_bytes(old_b, bus.din_b, bus.be_b) : old_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_IDLE: begin
                    if (clear_i) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // B's lane is dropped where A writes the same lane of the same word.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= CLEAR_VALUE;
        end else begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_b && bus.be_b[i] && !(wr_a && bus.be_a[i] && same_addr))
                    mem[bus.addr_b][i*8 +: 8] <= bus.din_b[i*8 +: 8];
                if (wr_a && bus.be_a[i])
                    mem[bus.addr_a][i*8 +: 8] <= bus.din_a[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_a_q   <= 1'b0;
            valid_b_q   <= 1'b0;
            collision_q <= 1'b0;
            dout_a_q    <= '0;
            dout_b_q    <= '0;
        end else begin
            valid_a_q   <= acc_a;
            valid_b_q   <= acc_b;
            collision_q <= collide;
            if (acc_a) dout_a_q <= rdata_a;
            if (acc_b) dout_b_q <= rdata_b;
        end
    end

    assign busy_o = busy_q;

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  valid_a_q2, valid_b_q2, collision_q2;
            logic [DATA_WIDTH-1:0] dout_a_q2, dout_b_q2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_a_q2   <= 1'b0;
                    valid_b_q2   <= 1'b0;
                    collision_q2 <= 1'b0;
                    dout_a_q2    <= '0;
                    dout_b_q2    <= '0;
                end else begin
                    valid_a_q2   <= valid_a_q;
                    valid_b_q2   <= valid_b_q;
                    collision_q2 <= collision_q;
                    if (valid_a_q) dout_a_q2 <= dout_a_q;
                    if (valid_b_q) dout_b_q2 <= dout_b_q;
                end
            end

            assign bus.valid_a  = valid_a_q2;
            assign bus.valid_b  = valid_b_q2;
            assign bus.dout_a   = dout_a_q2;
            assign bus.dout_b   = dout_b_q2;
            assign collision_o  = collision_q2;
        end else begin : g_nooreg
            assign bus.valid_a  = valid_a_q;
            assign bus.valid_b  = valid_b_q;
            assign bus.dout_a   = dout_a_q;
            assign bus.dout_b   = dout_b_q;
            assign collision_o  = collision_q;
        end
    endgenerate
endmodule

// File: tb/tb_or1k_dpram_be_clr.sv
// Scoreboard bench: two RAM instances (write-first/latency 1 and read-first/latency 2)
// share one directed stimulus stream; a monitor checks every valid and collision pulse.
module tb_or1k_dpram_be_clr;
    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_i = 1'b0;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [3:0]  be_a = '0, be_b = '0, addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;
    logic        busy0, busy1, col0, col1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } ent_t;

    ent_t  sq [6][$];
    string sname [6] = '{"dut0.a", "dut0.b", "dut1.a", "dut1.b", "dut0.coll", "dut1.coll"};
    logic        mv [6];
    logic [31:0] md [6];

    or1k_dpram_be_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if0 ();
    or1k_dpram_be_clr_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) if1 ();

    assign if0.en_a = en_a;   assign if1.en_a = en_a;
    assign if0.we_a = we_a;   assign if1.we_a = we_a;
    assign if0.be_a = be_a;   assign if1.be_a = be_a;
    assign if0.addr_a = addr_a; assign if1.addr_a = addr_a;
    assign if0.din_a = din_a; assign if1.din_a = din_a;
    assign if0.en_b = en_b;   assign if1.en_b = en_b;
    assign if0.we_b = we_b;   assign if1.we_b = we_b;
    assign if0.be_b = be_b;   assign if1.be_b = be_b;
    assign if0.addr_b = addr_b; assign if1.addr_b = addr_b;
    assign if0.din_b = din_b; assign if1.din_b = din_b;

    or1k_dpram_be_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(CV)
    ) dut0 (
        .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy0), .collision_o(col0), .bus(if0)
    );

    or1k_dpram_be_clr #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .clk(clk), .rst(rst), .clear_i(clear_i), .busy_o(busy1), .collision_o(col1), .bus(if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input int c, input logic [31:0] dv);
        ent_t e;
        e.cyc  = c;
        e.data = dv;
        sq[s].push_back(e);
    endtask

    // Drive one request cycle; ea0/eb0 are write-first results, ea1/eb1 read-first.
    task automatic acc(
        input logic ena, input logic wea, input logic [3:0] bea, input logic [3:0] aa, input logic [31:0] da,
        input logic enb, input logic web, input logic [3:0] beb, input logic [3:0] ab, input logic [31:0] db,
        input logic [31:0] ea0, input logic [31:0] ea1, input logic [31:0] eb0, input logic [31:0] eb1,
        input logic col, input logic clr
    );
        int c;
        @(posedge clk);
        #2;
        en_a = ena; we_a = wea; be_a = bea; addr_a = aa; din_a = da;
        en_b = enb; we_b = web; be_b = beb; addr_b = ab; din_b = db;
        clear_i = clr;
        c = cyc;
        if (ena) begin push(0, c + 1, ea0); push(2, c + 2, ea1); end
        if (enb) begin push(1, c + 1, eb0); push(3, c + 2, eb1); end
        if (col) begin push(4, c + 1, 32'h0); push(5, c + 2, 32'h0); end
    endtask

    task automatic idle();
        acc(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy0) break;
        end
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mv[0] = if0.valid_a; md[0] = if0.dout_a;
            mv[1] = if0.valid_b; md[1] = if0.dout_b;
            mv[2] = if1.valid_a; md[2] = if1.dout_a;
            mv[3] = if1.valid_b; md[3] = if1.dout_b;
            mv[4] = col0;        md[4] = 32'h0;
            mv[5] = col1;        md[5] = 32'h0;
            for (int s = 0; s < 6; s++) begin
                if (mv[s]) begin
                    n_tests++;
                    if (sq[s].size() == 0) begin
                        n_fail++;
                        $display("FAIL %s unexpected pulse at cycle %0d data %h", sname[s], cyc, md[s]);
                    end else begin
                        ent_t e;
                        e = sq[s].pop_front();
                        if (e.cyc != cyc || e.data !== md[s]) begin
                            n_fail++;
                            $display("FAIL %s: got %h at cycle %0d expected %h at cycle %0d",
                                     sname[s], md[s], cyc, e.data, e.cyc);
                        end
                    end
                end else if (sq[s].size() > 0 && sq[s][0].cyc <= cyc) begin
                    ent_t e;
                    e = sq[s].pop_front();
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s missing pulse: expected %h at cycle %0d", sname[s], e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst dout_a dut0", if0.dout_a, 32'h0);
        chk("rst dout_b dut0", if0.dout_b, 32'h0);
        chk("rst dout_a dut1", if1.dout_a, 32'h0);
        chk("rst dout_b dut1", if1.dout_b, 32'h0);
        chk("rst valid dut0", {if0.valid_a, if0.valid_b}, 32'h0);
        chk("rst valid dut1", {if1.valid_a, if1.valid_b}, 32'h0);
        chk("rst collision", {col0, col1}, 32'h0);
        chk("rst busy", {busy0, busy1}, 32'h3);

        // Interrupt the initial clear at counter 9, then let it complete.
        #1 rst = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid-clear rst busy", {busy0, busy1}, 32'h3);
        chk("mid-clear rst valid", {if0.valid_a, if1.valid_a}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        wait_idle(n);
        chk("busy edges after reset", n, 32'd16);
        chk("busy dut1 after reset", busy1, 32'h0);

        for (int i = 0; i < 16; i++) begin
            acc(1, 0, 4'h0, 4'(i), 32'h0, 1, 0, 4'h0, 4'(15 - i), 32'h0, CV, CV, CV, CV, 0, 0);
        end

        acc(1, 1, 4'hF, 4'd3, 32'h11223344, 0, 0, 4'h0, 4'd0, 32'h0, 32'h11223344, CV, 32'h0, 32'h0, 0, 0);
        acc(1, 1, 4'h5, 4'd3, 32'hAABBCCDD, 0, 0, 4'h0, 4'd0, 32'h0, 32'h11BB33DD, 32'h11223344, 32'h0, 32'h0, 0, 0);
        acc(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd3, 32'h0, 32'h0, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 0, 0);
        acc(0, 0, 4'h0, 4'd0, 32'h0, 1, 1, 4'h0, 4'd3, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 0, 0);
        acc(1, 0, 4'h0, 4'd3, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 32'h0, 32'h0, 0, 0);

        acc(1, 1, 4'hF, 4'd5, 32'h99, 0, 0, 4'h0, 4'd0, 32'h0, 32'h99, CV, 32'h0, 32'h0, 0, 0);
        acc(1, 1, 4'hF, 4'd5, 32'h55, 0, 0, 4'h0, 4'd0, 32'h0, 32'h55, 32'h99, 32'h0, 32'h0, 0, 0);
        acc(0, 0, 4'h0, 4'd0, 32'h0, 1, 0, 4'h0, 4'd5, 32'h0, 32'h0, 32'h0, 32'h55, 32'h55, 0, 0);

        acc(1, 1, 4'hF, 4'd9, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h0, CV, 32'h0, 32'h0, 0, 0);
        acc(1, 1, 4'h3, 4'd9, 32'hAAAAAAAA, 1, 1, 4'h6, 4'd9, 32'hBBBBBBBB,
            32'h0000AAAA, 32'h0, 32'h00BBBB00, 32'h0, 1, 0);
        acc(1, 0, 4'h0, 4'd9, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h00BBAAAA, 32'h00BBAAAA, 32'h0, 32'h0, 0, 0);

        acc(1, 1, 4'hF, 4'd7, 32'h1, 0, 0, 4'h0, 4'd0, 32'h0, 32'h1, CV, 32'h0, 32'h0, 0, 0);
        acc(1, 0, 4'h0, 4'd7, 32'h0, 1, 1, 4'hF, 4'd7, 32'h2, 32'h1, 32'h1, 32'h2, 32'h1, 1, 0);
        acc(1, 0, 4'h0, 4'd7, 32'h0, 1, 0, 4'h0, 4'd7, 32'h0, 32'h2, 32'h2, 32'h2, 32'h2, 0, 0);

        // Clear request alongside a read: the read completes, then accesses are ignored.
        acc(1, 0, 4'h0, 4'd7, 32'h0, 0, 0, 4'h0, 4'd0, 32'h0, 32'h2, 32'h2, 32'h0, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        chk("busy after clear_i", {busy0, busy1}, 32'h3);
        clear_i = 1'b0;
        en_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
        en_b = 1'b1; we_b = 1'b1; be_b = 4'hF; addr_b = 4'd1; din_b = 32'h12345678;
        wait_idle(n);
        chk("busy edges after clear_i", n, 32'd16);
        chk("busy dut1 after clear_i", busy1, 32'h0);

        acc(1, 0, 4'h0, 4'd7, 32'h0, 1, 0, 4'h0, 4'd1, 32'h0, CV, CV, CV, CV, 0, 0);
        acc(1, 0, 4'h0, 4'd9, 32'h0, 1, 0, 4'h0, 4'd15, 32'h0, CV, CV, CV, CV, 0, 0);
        idle();
        repeat (5) @(posedge clk);
        #1;
        for (int s = 0; s < 6; s++) begin
            chk({"drained ", sname[s]}, sq[s].size(), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
